// File: rtl/data_ram_resp.sv
// data_ram_resp: 32-bit word data RAM behind the CPU data port.
// Byte/half/word loads and stores with sign/zero extension, a one-cycle
// ready_o pulse per access and err_o for misaligned or reserved types.
// Optional feature macro: RAM_WAIT_EN inserts WAIT_CYCLES wait states
// (busy_o high) between acceptance and response; undefined gives
// single-cycle responses with busy_o tied low.
//
// Handshake: ce_i is a request strobe sampled on a rising edge only while
// the FSM is in IDLE or RESP (ignored in WAIT). Each accepted request
// produces exactly one ready_o pulse; err_o and the new data_o are valid
// in that same cycle, and data_o holds until the next successful load.
module data_ram_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  datatype_sel_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] r_data_o;
  logic        r_err;

  logic        w_accept;
  logic        w_do_access;
  logic        w_acc_we;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_data;
  logic [2:0]  w_acc_type;

  assign w_accept = ce_i && (r_state != S_WAIT);

`ifdef RAM_WAIT_EN
  localparam logic [3:0] LP_WAIT_LAST = 4'(WAIT_CYCLES - 1);

  logic        r_req_we;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_data;
  logic [2:0]  r_req_type;
  logic [3:0]  r_wait_cnt;

  // Capture the request on acceptance; the access itself runs from these.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_we   <= 1'b0;
      r_req_addr <= '0;
      r_req_data <= '0;
      r_req_type <= '0;
    end else if (w_accept) begin
      r_req_we   <= we_i;
      r_req_addr <= addr_i;
      r_req_data <= data_i;
      r_req_type <= datatype_sel_i;
    end
  end

  // Count cycles spent in WAIT; restarts from zero on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign w_acc_we    = r_req_we;
  assign w_acc_addr  = r_req_addr;
  assign w_acc_data  = r_req_data;
  assign w_acc_type  = r_req_type;
  // Access happens on the edge that leaves the last wait cycle.
  assign w_do_access = (r_state == S_WAIT) && (r_wait_cnt == LP_WAIT_LAST);
  assign busy_o      = (r_state == S_WAIT);

  // Next-state: accepted requests wait, then respond.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_WAIT:  w_state_nxt = (r_wait_cnt == LP_WAIT_LAST) ? S_RESP : S_WAIT;
      default: w_state_nxt = w_accept ? S_WAIT : S_IDLE;
    endcase
  end
`else
  // Without wait states the access uses the live inputs on the accept edge;
  // rst gates it so a store presented during reset never lands.
  assign w_acc_we    = we_i;
  assign w_acc_addr  = addr_i;
  assign w_acc_data  = data_i;
  assign w_acc_type  = datatype_sel_i;
  assign w_do_access = w_accept && rst;
  assign busy_o      = 1'b0;

  // Next-state: every accepted request responds in the following cycle.
  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_accept) begin
      w_state_nxt = S_RESP;
    end
  end
`endif

  // Address decode and error classification.
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_lane;
  logic                  w_err;
  logic [31:0]           w_rd_word;
  logic [31:0]           w_wr_word;
  logic [31:0]           w_ld_data;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_sext;

  assign w_idx     = w_acc_addr[DEPTH_LOG2+1:2];
  assign w_lane    = w_acc_addr[1:0];
  assign w_rd_word = r_mem[w_idx];
  assign w_sext    = ~w_acc_type[2];

  // Reserved types and misaligned half/word accesses are errors.
  always_comb begin
    w_err = 1'b0;
    case (w_acc_type)
      3'b001, 3'b101: w_err = w_lane[0];
      3'b010:         w_err = (w_lane != 2'b00);
      3'b000, 3'b100: w_err = 1'b0;
      default:        w_err = 1'b1;
    endcase
  end

  // Lane merge for stores and lane extract/extend for loads.
  always_comb begin
    w_wr_word = w_rd_word;
    w_ld_data = w_rd_word;
    w_byte    = w_rd_word[{w_lane, 3'b000} +: 8];
    w_half    = w_rd_word[{w_lane[1], 4'b0000} +: 16];
    case (w_acc_type[1:0])
      2'b00: begin
        w_wr_word[{w_lane, 3'b000} +: 8] = w_acc_data[7:0];
        w_ld_data = {{24{w_sext & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_wr_word[{w_lane[1], 4'b0000} +: 16] = w_acc_data[15:0];
        w_ld_data = {{16{w_sext & w_half[15]}}, w_half};
      end
      default: begin
        w_wr_word = w_acc_data;
        w_ld_data = w_rd_word;
      end
    endcase
  end

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_do_access && w_acc_we && !w_err) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response registers: error flag every access, data only on good loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_o <= '0;
      r_err    <= 1'b0;
    end else if (w_do_access) begin
      r_err <= w_err;
      if (!w_acc_we && !w_err) begin
        r_data_o <= w_ld_data;
      end
    end
  end

  assign ready_o     = (r_state == S_RESP);
  assign err_o       = ready_o & r_err;
  assign data_o      = r_data_o;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: directed and randomized load/store traffic against a
// word-array reference model; honours RAM_WAIT_EN for response latency.
module tb_data_ram_resp;

  localparam int DEPTH_LOG2  = 10;
  localparam int WAIT_CYCLES = 2;
`ifdef RAM_WAIT_EN
  localparam int LP_LAT = WAIT_CYCLES;
`else
  localparam int LP_LAT = 0;
`endif

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [2:0]  datatype_sel_i;
  logic [31:0] data_o;
  logic        ready_o;
  logic        busy_o;
  logic        err_o;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  logic [31:0] mdl_mem [int];
  logic [31:0] mdl_data_o;

  data_ram_resp #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .ce_i          (ce_i),
    .we_i          (we_i),
    .addr_i        (addr_i),
    .data_i        (data_i),
    .datatype_sel_i(datatype_sel_i),
    .data_o        (data_o),
    .ready_o       (ready_o),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .o_dbg_state   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic on a word array.
  function automatic void mdl_access(input logic we, input logic [31:0] addr,
                                     input logic [31:0] data, input logic [2:0] typ,
                                     output logic err);
    int idx;
    int lane;
    int nbytes;
    logic [31:0] w;
    idx    = int'((addr >> 2) % (1 << DEPTH_LOG2));
    lane   = int'(addr % 4);
    nbytes = (typ[1:0] == 2'd0) ? 1 : (typ[1:0] == 2'd1) ? 2 : 4;
    err = (typ == 3'd3) || (typ == 3'd6) || (typ == 3'd7) ||
          (nbytes == 2 && (addr % 2) != 0) || (nbytes == 4 && lane != 0);
    if (err) return;
    w = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
    if (we) begin
      for (int b = 0; b < nbytes; b++) begin
        w[8*(lane+b) +: 8] = data[8*b +: 8];
      end
      mdl_mem[idx] = w;
    end else begin
      w = w >> (8 * lane);
      if (nbytes == 1) begin
        w = w & 32'hFF;
        if (!typ[2] && w >= 32'h80) w = w | 32'hFFFFFF00;
      end else if (nbytes == 2) begin
        w = w & 32'hFFFF;
        if (!typ[2] && w >= 32'h8000) w = w | 32'hFFFF0000;
      end
      mdl_data_o = w;
    end
  endfunction

  task automatic check_resp(input int n);
    logic [31:0] e;
    logic        ee;
    e  = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    chk("latency", n, LP_LAT);
    chk("ready", ready_o, 1);
    chk("busy_resp", busy_o, 0);
    chk("err_o", err_o, ee);
    chk("data_o", data_o, e);
    @(negedge clk);
    chk("ready_pulse", ready_o, 0);
    chk("err_idle", err_o, 0);
    chk("data_hold", data_o, e);
  endtask

  // Driver: one access, wait (bounded) for ready_o, then score it.
  task automatic do_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] typ);
    logic e;
    int   n;
    mdl_access(we, addr, data, typ, e);
    exp_q.push_back(mdl_data_o);
    exp_err_q.push_back(e);
    @(negedge clk);
    ce_i = 1'b1; we_i = we; addr_i = addr; data_i = data; datatype_sel_i = typ;
    @(negedge clk);
    ce_i = 1'b0;
    n = 0;
    while (ready_o !== 1'b1 && n < 40) begin
`ifdef RAM_WAIT_EN
      chk("busy_wait", busy_o, 1);
      ce_i   = 1'($urandom_range(0, 1));
      we_i   = 1'($urandom_range(0, 1));
      addr_i = $urandom;
      data_i = $urandom;
`endif
      @(negedge clk);
      n++;
    end
    ce_i = 1'b0;
    we_i = 1'b0;
    check_resp(n);
  endtask

  task automatic apply_reset_check();
    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_state", dbg_state, 0);
    mdl_data_o = 32'h0;
  endtask

  initial begin
    logic        e;
    logic [31:0] a;
    ce_i = 0; we_i = 0; addr_i = 0; data_i = 0; datatype_sel_i = 0; rst = 0;
    mdl_data_o = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    apply_reset_check();
    rst = 1;

    // Preload words 0..15 so every later load hits known contents.
    for (int i = 0; i < 16; i++) do_access(1, i * 4, $urandom, 3'b010);

    // Directed: word store/load, byte lanes, signed/unsigned, errors.
    do_access(1, 32'h10, 32'h12345678, 3'b010);
    do_access(0, 32'h10, 32'h0, 3'b010);
    chk("dir_word", mdl_data_o, 32'h12345678);
    do_access(1, 32'h13, 32'h000000AB, 3'b000);
    do_access(0, 32'h13, 32'h0, 3'b000);
    do_access(0, 32'h13, 32'h0, 3'b100);
    do_access(0, 32'h10, 32'h0, 3'b010);
    do_access(0, 32'h11, 32'h0, 3'b001);
    do_access(0, 32'h10, 32'h0, 3'b010);
    do_access(1, 32'h12, 32'h0000CAFE, 3'b001);
    do_access(0, 32'h12, 32'h0, 3'b001);
    do_access(0, 32'h12, 32'h0, 3'b101);
    do_access(1, 32'h11, 32'hFFFFFFFF, 3'b010);
    do_access(1, 32'h10, 32'h0, 3'b011);
    do_access(0, 32'hFFFFF010, 32'h0, 3'b010);

`ifndef RAM_WAIT_EN
    // Back-to-back loads: one response per cycle.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_ready", ready_o, 1);
        chk("b2b_err", err_o, exp_err_q.pop_front());
        chk("b2b_data", data_o, exp_q.pop_front());
      end
      if (i < 4) begin
        mdl_access(0, i * 4, 0, 3'b010, e);
        exp_q.push_back(mdl_data_o);
        exp_err_q.push_back(e);
        ce_i = 1; we_i = 0; addr_i = i * 4; datatype_sel_i = 3'b010;
      end else begin
        ce_i = 0;
      end
    end
    @(negedge clk);
    chk("b2b_end", ready_o, 0);
`endif

    // Reset in the middle of a store aborts it.
    do_access(1, 32'h20, 32'h0BADF00D, 3'b010);
    @(negedge clk);
    ce_i = 1; we_i = 1; addr_i = 32'h20; data_i = 32'hDEADBEEF; datatype_sel_i = 3'b010;
`ifdef RAM_WAIT_EN
    @(negedge clk);
    ce_i = 0;
    chk("busy_before_rst", busy_o, 1);
`endif
    rst = 0;
    apply_reset_check();
    @(negedge clk);
    ce_i = 0; we_i = 0;
    @(negedge clk);
    rst = 1;
    do_access(0, 32'h20, 32'h0, 3'b010);
    chk("rst_abort", mdl_data_o, 32'h0BADF00D);

    // Randomized traffic over words 0..15 with aliasing high address bits.
    for (int i = 0; i < 80; i++) begin
      a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) |
          32'($urandom_range(0, 3));
      do_access(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
